// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the two-requester channel arbiter.
package mux_arb_pkg;

    localparam int CHAN_W = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mux2to1_4.sv
// Plain 2:1 selector for the shared channel; zeroing while idle is the parent's job.
module mux2to1_4
    import mux_arb_pkg::*;
(
    input  logic [CHAN_W-1:0] x,
    input  logic [CHAN_W-1:0] y,
    input  logic              s,
    output logic [CHAN_W-1:0] m
);

    // Pick y when the select points at B, otherwise x.
    always_comb begin
        m = (s == SEL_B) ? y : x;
    end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin, time-sliced arbiter for two requesters sharing one 4-bit channel.
// Optional feature: define MUX_ARB_STATS_EN to add the 8-bit switch_cnt output.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic              req_a,
    input  logic [CHAN_W-1:0] data_a,
    input  logic              req_b,
    input  logic [CHAN_W-1:0] data_b,
    output logic              grant_a,
    output logic              grant_b,
    output logic              sel,
    output logic [CHAN_W-1:0] mux_out,
    output logic              busy
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [7:0]        switch_cnt
`endif
);

    localparam logic [7:0] SLICE_LAST = 8'(SLICE - 1);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic [7:0]        slice_cnt;
    logic [7:0]        slice_cnt_nxt;
    logic              last_owner;
    logic              last_owner_nxt;
    logic              sel_nxt;
    logic              entering;
    logic              new_owner;
    logic [CHAN_W-1:0] chan_data;

    // Next-state decision: tie-break by last owner, hand over without an idle bubble,
    // and only run the slice counter while both sides are asking.
    always_comb begin
        state_nxt     = state;
        slice_cnt_nxt = slice_cnt;
        case (state)
            IDLE: begin
                slice_cnt_nxt = '0;
                if (req_a && req_b) begin
                    state_nxt = (last_owner == SEL_B) ? OWN_A : OWN_B;
                end else if (req_a) begin
                    state_nxt = OWN_A;
                end else if (req_b) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    state_nxt = req_b ? OWN_B : IDLE;
                end else if (req_b) begin
                    if (slice_cnt == SLICE_LAST) begin
                        state_nxt = OWN_B;
                    end else begin
                        slice_cnt_nxt = slice_cnt + 8'd1;
                    end
                end else begin
                    slice_cnt_nxt = '0;
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_nxt = req_a ? OWN_A : IDLE;
                end else if (req_a) begin
                    if (slice_cnt == SLICE_LAST) begin
                        state_nxt = OWN_A;
                    end else begin
                        slice_cnt_nxt = slice_cnt + 8'd1;
                    end
                end else begin
                    slice_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt     = IDLE;
                slice_cnt_nxt = '0;
            end
        endcase

        if (state_nxt != state) begin
            slice_cnt_nxt = '0;
        end

        entering       = (state_nxt != state) && (state_nxt != IDLE);
        new_owner      = (state_nxt == OWN_B) ? SEL_B : SEL_A;
        last_owner_nxt = entering ? new_owner : last_owner;
        sel_nxt        = entering ? new_owner : sel;
    end

    // State, slice counter, last owner and select register; reset makes A win the first tie.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state      <= IDLE;
            slice_cnt  <= '0;
            last_owner <= SEL_B;
            sel        <= SEL_A;
        end else begin
            state      <= state_nxt;
            slice_cnt  <= slice_cnt_nxt;
            last_owner <= last_owner_nxt;
            sel        <= sel_nxt;
        end
    end

`ifdef MUX_ARB_STATS_EN
    // Count ownership changes between different sides, sticking at 255.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            switch_cnt <= '0;
        end else if (entering && (new_owner != last_owner) && (switch_cnt != 8'hFF)) begin
            switch_cnt <= switch_cnt + 8'd1;
        end
    end
`endif

    assign grant_a = (state == OWN_A);
    assign grant_b = (state == OWN_B);
    assign busy    = grant_a | grant_b;

    mux2to1_4 u_mux (
        .x (data_a),
        .y (data_b),
        .s (sel),
        .m (chan_data)
    );

    // Drive the channel only while someone owns it.
    always_comb begin
        mux_out = busy ? chan_data : '0;
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// Self-checking bench for mux_arbiter: directed scenarios plus random traffic
// compared against a tenure-based behavioural model.
module tb_mux_arbiter;

    localparam int SLICE = 8;

    logic       CLOCK_50 = 1'b0;
    logic       RESET    = 1'b1;
    logic       req_a    = 1'b0;
    logic [3:0] data_a   = 4'h0;
    logic       req_b    = 1'b0;
    logic [3:0] data_b   = 4'h0;
    logic       grant_a;
    logic       grant_b;
    logic       sel;
    logic [3:0] mux_out;
    logic       busy;
`ifdef MUX_ARB_STATS_EN
    logic [7:0] switch_cnt;
`endif

    int checks = 0;
    int passed = 0;

    // Model: who owns (0 none, 1 A, 2 B), who owned last, how many edges of this
    // tenure the other side has spent waiting, and the handoff count.
    int m_owner    = 0;
    int m_last     = 2;
    int m_sel      = 0;
    int m_waited   = 0;
    int m_switches = 0;

    mux_arbiter #(.SLICE(SLICE)) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .req_a    (req_a),
        .data_a   (data_a),
        .req_b    (req_b),
        .data_b   (data_b),
        .grant_a  (grant_a),
        .grant_b  (grant_b),
        .sel      (sel),
        .mux_out  (mux_out),
        .busy     (busy)
`ifdef MUX_ARB_STATS_EN
        ,
        .switch_cnt (switch_cnt)
`endif
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void modelEdge(input bit ra, input bit rb, input bit rst);
        int nxt;
        bit mine;
        bit other;
        if (rst) begin
            m_owner    = 0;
            m_last     = 2;
            m_sel      = 0;
            m_waited   = 0;
            m_switches = 0;
            return;
        end
        nxt = m_owner;
        if (m_owner == 0) begin
            if (ra && rb)  nxt = (m_last == 1) ? 2 : 1;
            else if (ra)   nxt = 1;
            else if (rb)   nxt = 2;
        end else begin
            mine  = (m_owner == 1) ? ra : rb;
            other = (m_owner == 1) ? rb : ra;
            if (!mine) begin
                nxt = other ? (3 - m_owner) : 0;
            end else if (other) begin
                m_waited++;
                if (m_waited >= SLICE) nxt = 3 - m_owner;
            end else begin
                m_waited = 0;
            end
        end
        if (nxt != m_owner) begin
            m_waited = 0;
            if (nxt != 0) begin
                if (nxt != m_last && m_switches < 255) m_switches++;
                m_last = nxt;
                m_sel  = nxt - 1;
            end
        end
        m_owner = nxt;
    endfunction

    // Drive one cycle of inputs at the falling edge, advance the model on the rising
    // edge and compare every output shortly afterwards.
    task automatic applyStimulus(input bit ra, input logic [3:0] da,
                                 input bit rb, input logic [3:0] db, input bit rst);
        int exp_mux;
        @(negedge CLOCK_50);
        req_a  = ra;
        data_a = da;
        req_b  = rb;
        data_b = db;
        RESET  = rst;
        @(posedge CLOCK_50);
        modelEdge(ra, rb, rst);
        #1;
        exp_mux = (m_owner == 1) ? int'(da) : (m_owner == 2) ? int'(db) : 0;
        checkOutput("grant_a", int'(grant_a), (m_owner == 1) ? 1 : 0);
        checkOutput("grant_b", int'(grant_b), (m_owner == 2) ? 1 : 0);
        checkOutput("busy",    int'(busy),    (m_owner != 0) ? 1 : 0);
        checkOutput("sel",     int'(sel),     m_sel);
        checkOutput("mux_out", int'(mux_out), exp_mux);
`ifdef MUX_ARB_STATS_EN
        checkOutput("switch_cnt", int'(switch_cnt), m_switches);
`endif
    endtask

    initial begin
        int run;
        bit prev_a;

        // Reset held two cycles with both sides requesting.
        applyStimulus(1'b1, 4'h3, 1'b1, 4'h6, 1'b1);
        applyStimulus(1'b1, 4'h3, 1'b1, 4'h6, 1'b1);
        checkOutput("rst_grants", int'({grant_a, grant_b}), 0);
        checkOutput("rst_sel",    int'(sel),     0);
        checkOutput("rst_mux",    int'(mux_out), 0);
        applyStimulus(1'b1, 4'h3, 1'b1, 4'h6, 1'b0);
        checkOutput("first_tie_a", int'(grant_a), 1);

        // A alone for 20 cycles: no time limit.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 4'hA, 1'b0, 4'h1, 1'b0);
            checkOutput("hold_a", int'(grant_a), 1);
            checkOutput("hold_a_mux", int'(mux_out), 4'hA);
        end

        // Both requesting: each tenure lasts exactly SLICE cycles, no idle gap.
        run    = 1;
        prev_a = grant_a;
        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b1, 4'hC, 1'b1, 4'h3, 1'b0);
            checkOutput("no_idle", int'(busy), 1);
            if (grant_a == prev_a) begin
                run++;
            end else begin
                checkOutput("slice_len", run, SLICE);
                run = 1;
            end
            prev_a = grant_a;
        end

        // Owner A drops while B waits: direct handoff.
        applyStimulus(1'b1, 4'h9, 1'b0, 4'h5, 1'b0);
        applyStimulus(1'b0, 4'h9, 1'b1, 4'h5, 1'b0);
        checkOutput("handoff_b",   int'(grant_b), 1);
        checkOutput("handoff_mux", int'(mux_out), 4'h5);

        // Reset mid-B tenure after five contested cycles, then A wins the tie.
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4'h2, 1'b1, 4'h7, 1'b0);
        checkOutput("pre_rst_b",   int'(grant_b), 1);
        checkOutput("pre_rst_cnt", int'(dut.slice_cnt), 5);
        applyStimulus(1'b1, 4'h2, 1'b1, 4'h7, 1'b1);
        checkOutput("mid_rst_busy", int'(busy), 0);
        checkOutput("mid_rst_cnt",  int'(dut.slice_cnt), 0);
        applyStimulus(1'b1, 4'h2, 1'b1, 4'h7, 1'b0);
        checkOutput("post_rst_a", int'(grant_a), 1);

        // Random traffic, biased towards contention, with occasional resets.
        for (int i = 0; i < 800; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, 4'($urandom),
                          $urandom_range(0, 3) != 0, 4'($urandom),
                          $urandom_range(0, 63) == 0);
        end

`ifdef MUX_ARB_STATS_EN
        // 300 forced handoffs drive the counter into saturation.
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (i % 2 == 0) applyStimulus(1'b1, 4'h1, 1'b0, 4'h2, 1'b0);
            else            applyStimulus(1'b0, 4'h1, 1'b1, 4'h2, 1'b0);
        end
        checkOutput("switch_sat", int'(switch_cnt), 255);
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mux_arbiter.md
MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 The module SHALL have parameter SLICE, default 8: maximum cycles an owner holds the grant while the other requester waits (legal 2..255).
REQ-002 The module SHALL have port CLOCK_50, input, 1 bit: sole clock; all state changes on the rising edge.
REQ-003 The module SHALL have port RESET, input, 1 bit: synchronous active-high reset.
REQ-004 The module SHALL have port req_a, input, 1 bit: requester A wants the shared 4-bit channel.
REQ-005 The module SHALL have port data_a, input, 4 bits: requester A data.
REQ-006 The module SHALL have port req_b, input, 1 bit: requester B wants the shared 4-bit channel.
REQ-007 The module SHALL have port data_b, input, 4 bits: requester B data.
REQ-008 The module SHALL have port grant_a, output, 1 bit: A owns the channel.
REQ-009 The module SHALL have port grant_b, output, 1 bit: B owns the channel.
REQ-010 The module SHALL have port sel, output, 1 bit: mux select, 0 = A, 1 = B.
REQ-011 The module SHALL have port mux_out, output, 4 bits: shared channel data.
REQ-012 The module SHALL have port busy, output, 1 bit: equals grant_a | grant_b.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, OWN_A and OWN_B; grant_a = (state==OWN_A) and grant_b = (state==OWN_B), both registered, never asserted together.
REQ-014 In IDLE, req_a only SHALL go to OWN_A, req_b only SHALL go to OWN_B, neither SHALL stay in IDLE; grant latency from first sampled request is 1 cycle.
REQ-015 In IDLE with req_a and req_b both high, the FSM SHALL grant the side opposite last_owner (round-robin).
REQ-016 In OWN_X with req_X low, the FSM SHALL go directly to the other OWN state if the other request is high (no IDLE bubble), else to IDLE.
REQ-017 In OWN_X with req_X high and the other request low, the FSM SHALL hold, with the slice counter held at 0 (no time limit).
REQ-018 In OWN_X with both requests high, the slice counter SHALL increment each cycle; on the edge where it equals SLICE-1 the FSM SHALL switch to the other OWN state and clear the counter.
REQ-019 The slice counter SHALL clear on every state change, and at most SLICE consecutive grant cycles SHALL occur while the other side waits.
REQ-020 last_owner SHALL update on every entry into OWN_A or OWN_B.
REQ-021 sel SHALL be registered, track the owning side, and hold its last value in IDLE.
REQ-022 mux_out SHALL be combinational: data_a when grant_a, data_b when grant_b, 4'b0000 in IDLE.

Reset
REQ-023 While RESET is high at a clock edge, the FSM SHALL enter IDLE, grants, sel, busy and the slice counter SHALL be 0, and last_owner SHALL be B (A wins the first tie).
REQ-024 A RESET asserted mid-ownership SHALL drop the grant at that edge regardless of requests, and arbitration SHALL resume on the first edge after RESET deasserts.

Configuration
REQ-025 With macro MUX_ARB_STATS_EN defined, the module SHALL add an 8-bit output switch_cnt that increments on each entry into an OWN state whose owner differs from last_owner, saturates at 255, and clears on reset.
REQ-026 Without MUX_ARB_STATS_EN, switch_cnt and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 Package mux_arb_pkg SHALL hold the state typedef (IDLE/OWN_A/OWN_B), the SEL_A/SEL_B constants and the channel width constant (4).
REQ-028 The 4-bit 2:1 data selection SHALL be one sub-module, mux2to1_4 (inputs x, y, s; output m), instantiated once; the IDLE zeroing SHALL be done in the parent.

Verification
REQ-029 The bench SHALL cover this scenario: RESET=1 for 2 cycles with req_a=req_b=1 -> grants=0, sel=0, mux_out=0; on the first edge after release -> grant_a=1.
REQ-030 The bench SHALL cover this scenario: req_a=1, data_a=4'hA held for 20 cycles, req_b=0 -> grant_a stays 1 for all 20 cycles, mux_out=4'hA.
REQ-031 The bench SHALL cover this scenario: both requests high continuously, SLICE=8 -> the grant alternates A/B every 8 cycles, sel toggles, with no IDLE cycle between.
REQ-032 The bench SHALL cover this scenario: OWN_A, req_a drops while req_b=1 and data_b=4'h5 -> grant_b=1 on the next edge and mux_out=4'h5.
REQ-033 The bench SHALL cover this scenario: RESET pulsed for 1 cycle mid OWN_B with slice count 5 -> IDLE and counter 0; afterwards with both requests high -> A is granted.
REQ-034 With MUX_ARB_STATS_EN defined, the bench SHALL cover this scenario: 300 forced handoffs -> switch_cnt=255 (saturated).
